// File: rtl/whack_score_engine.sv
// whack_score_engine: whack-a-mole hit/miss scoring with streak bonus and IDLE/PLAY/PAUSE/OVER control
// ports: clk, key_esc (sync reset), key_space (start/pause), mole_valid/mole_pos (shown mole), btn (buttons)
//        score/misses/streak counters, hit_pulse/miss_pulse, state, win/lose, score_full/score_low flags
module whack_score_engine #(
  parameter int N_HOLES = 5,
  parameter int SCORE_W = 8,
  parameter int WIN_SCORE = 15,
  parameter int LOSE_MISSES = 5,
  parameter int BONUS_STREAK = 3,
  parameter int LOW_THRESH = 5,
  localparam int POS_W = $clog2(N_HOLES),
  localparam int MISS_W = $clog2(LOSE_MISSES + 1)
) (
  input  logic               clk,
  input  logic               key_esc,
  input  logic               key_space,
  input  logic               mole_valid,
  input  logic [POS_W-1:0]   mole_pos,
  input  logic [N_HOLES-1:0] btn,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  misses,
  output logic [3:0]         streak,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [1:0]         state,
  output logic               win,
  output logic               lose,
  output logic               score_full,
  output logic               score_low
);
  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, OVER = 2'd3;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  logic [1:0] st, st_nx;
  logic [N_HOLES-1:0] btn_q, press;
  logic space_q, start, hit_lock, locked, eval, hit, miss, win_c, lose_c, done, done_nx;
  logic [POS_W-1:0] lock_pos;
  logic [SCORE_W:0] sum;
  logic [SCORE_W-1:0] score_nx;
  logic [MISS_W-1:0] misses_nx;
  logic [3:0] streak_nx;
  always_comb begin
    press = btn & ~btn_q;
    start = key_space & ~space_q;
    // the lock only guards the very mole that was hit
    locked = hit_lock && mole_valid && mole_pos == lock_pos;
    win_c = 32'(score) >= WIN_SCORE;
    lose_c = 32'(misses) >= LOSE_MISSES;
    done = win_c || lose_c;
    eval = st == PLAY && !done && |press;
    hit = eval && mole_valid && |(press & (N_HOLES'(1) << mole_pos)) && !locked;
    miss = eval && !hit;
    sum = {1'b0, score} + ((32'(streak) >= BONUS_STREAK) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
    score_nx = !hit ? score : sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    misses_nx = (miss && 32'(misses) < LOSE_MISSES) ? misses + MISS_W'(1) : misses;
    streak_nx = hit ? streak + {3'd0, streak != 4'd15} : miss ? 4'd0 : streak;
    // a start coinciding with the game-ending hit/miss must not pause the game
    done_nx = 32'(score_nx) >= WIN_SCORE || 32'(misses_nx) >= LOSE_MISSES;
  end
  always_comb begin
    st_nx = (st == IDLE && start) ? PLAY :
            (st == PLAY && done) ? OVER :
            (st == PLAY && start && !done_nx) ? PAUSE :
            (st == PAUSE && start) ? PLAY : st;
  end
  always_ff @(posedge clk) st <= key_esc ? IDLE : st_nx;
  always_ff @(posedge clk) begin
    btn_q <= btn;
    space_q <= key_space;
    if (key_esc) begin
      score <= '0;
      misses <= '0;
      streak <= '0;
      hit_lock <= 1'b0;
      lock_pos <= '0;
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
      win <= 1'b0;
      lose <= 1'b0;
    end else begin
      score <= score_nx;
      misses <= misses_nx;
      streak <= streak_nx;
      hit_lock <= hit || locked;
      lock_pos <= hit ? mole_pos : lock_pos;
      hit_pulse <= hit;
      miss_pulse <= miss;
      win <= (st == PLAY && done) ? win_c : win;
      lose <= (st == PLAY && done) ? !win_c : lose;
    end
  end
  always_comb begin
    state = st;
    score_full = score == SCORE_MAX;
    score_low = 32'(score) < LOW_THRESH;
  end
endmodule

// File: tb/tb_whack_score_engine.sv
// tb_whack_score_engine: scoreboard bench for whack_score_engine with directed vectors
module tb_whack_score_engine;
  logic clk = 1'b0, key_esc = 1'b1, key_space = 1'b0, mole_valid = 1'b0, sel = 1'b0;
  logic [2:0] mole_pos = 3'd0;
  logic [4:0] btn = 5'd0;
  logic [7:0] score1;
  logic [3:0] score2, streak1, streak2;
  logic [2:0] misses1, misses2;
  logic [1:0] state1, state2;
  logic hp1, mp1, hp2, mp2, win1, lose1, win2, lose2, full1, low1, full2, low2;
  logic [16:0] q[$];
  logic [16:0] mon_got;
  int checks = 0, failures = 0;
  int fpos[3] = '{0, 1, 4};
  int fsc[3] = '{2, 3, 5};
  int wsc[11] = '{1, 2, 3, 5, 7, 9, 11, 13, 15, 15, 15};
  always #5 clk = ~clk;
  whack_score_engine dut1 (
    .clk(clk), .key_esc(key_esc), .key_space(key_space), .mole_valid(mole_valid), .mole_pos(mole_pos),
    .btn(btn), .score(score1), .misses(misses1), .streak(streak1), .hit_pulse(hp1), .miss_pulse(mp1),
    .state(state1), .win(win1), .lose(lose1), .score_full(full1), .score_low(low1)
  );
  whack_score_engine #(.SCORE_W(4), .WIN_SCORE(20)) dut2 (
    .clk(clk), .key_esc(key_esc), .key_space(key_space), .mole_valid(mole_valid), .mole_pos(mole_pos),
    .btn(btn), .score(score2), .misses(misses2), .streak(streak2), .hit_pulse(hp2), .miss_pulse(mp2),
    .state(state2), .win(win2), .lose(lose2), .score_full(full2), .score_low(low2)
  );
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (sel ? (hp2 | mp2) : (hp1 | mp1)) begin
      mon_got = sel ? {hp2, mp2, 4'd0, score2, misses2, streak2} : {hp1, mp1, score1, misses1, streak1};
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse got=%0h exp=none", mon_got);
      end else chk("pulse", 32'(mon_got), 32'(q.pop_front()));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic mole(logic v, logic [2:0] p);
    mole_valid = v;
    mole_pos = p;
    step();
  endtask
  task automatic act(logic [4:0] b, logic h, int sc, int mi, int sk);
    q.push_back({h, ~h, 8'(sc), 3'(mi), 4'(sk)});
    btn = b;
    step();
    btn = 5'd0;
    step();
  endtask
  task automatic tap();
    key_space = 1'b1;
    step();
    key_space = 1'b0;
    step();
  endtask
  task automatic rst();
    key_esc = 1'b1;
    step();
    key_esc = 1'b0;
    step();
  endtask
  initial begin
    rst();
    chk("rst_state", 32'(state1), 0);
    chk("rst_score", 32'(score1), 0);
    chk("rst_misses", 32'(misses1), 0);
    chk("rst_streak", 32'(streak1), 0);
    chk("rst_low", 32'(low1), 1);
    chk("rst_full", 32'(full1), 0);
    chk("rst_winlose", 32'({win1, lose1}), 0);
    tap();
    chk("start_play", 32'(state1), 1);
    mole(1'b1, 3'd2);
    act(5'b00100, 1'b1, 1, 0, 1);
    chk("pulse_one_cycle", 32'(hp1), 0);
    for (int i = 0; i < 3; i++) begin
      mole(1'b0, 3'd0);
      mole(1'b1, 3'(fpos[i]));
      act(5'(1 << fpos[i]), 1'b1, fsc[i], 0, i + 2);
    end
    chk("low_clear", 32'(low1), 0);
    mole(1'b0, 3'd0);
    mole(1'b1, 3'd0);
    act(5'b01000, 1'b0, 5, 1, 0);
    mole(1'b0, 3'd0);
    mole(1'b1, 3'd3);
    act(5'b01000, 1'b1, 6, 1, 1);
    act(5'b01000, 1'b0, 6, 2, 0);
    mole(1'b0, 3'd0);
    mole(1'b1, 3'd1);
    act(5'b00011, 1'b1, 7, 2, 1);
    mole(1'b0, 3'd0);
    mole(1'b1, 3'd1);
    act(5'b11100, 1'b0, 7, 3, 0);
    mole(1'b0, 3'd0);
    tap();
    chk("pause", 32'(state1), 2);
    mole(1'b1, 3'd2);
    btn = 5'b00100;
    step();
    step();
    tap();
    chk("resume", 32'(state1), 1);
    step();
    step();
    chk("held_no_score", 32'(score1), 7);
    btn = 5'd0;
    step();
    act(5'b00100, 1'b1, 8, 3, 1);
    rst();
    chk("midgame_rst_state", 32'(state1), 0);
    chk("midgame_rst_score", 32'(score1), 0);
    tap();
    mole(1'b0, 3'd0);
    for (int i = 1; i <= 5; i++) act(5'b00001, 1'b0, 0, i, 0);
    chk("lose_state", 32'(state1), 3);
    chk("lose_flag", 32'(lose1), 1);
    chk("lose_nowin", 32'(win1), 0);
    btn = 5'b00001;
    tap();
    btn = 5'd0;
    step();
    chk("over_held", 32'(state1), 3);
    chk("over_misses", 32'(misses1), 5);
    rst();
    chk("over_rst_state", 32'(state1), 0);
    chk("over_rst_misses", 32'(misses1), 0);
    chk("over_rst_lose", 32'(lose1), 0);
    chk("over_rst_low", 32'(low1), 1);
    tap();
    for (int i = 0; i < 8; i++) begin
      mole(1'b0, 3'd0);
      mole(1'b1, 3'(i % 5));
      act(5'(1 << (i % 5)), 1'b1, wsc[i], 0, i + 1);
    end
    mole(1'b0, 3'd0);
    mole(1'b1, 3'd3);
    q.push_back({2'b10, 8'd15, 3'd0, 4'd9});
    btn = 5'b01000;
    key_space = 1'b1;
    step();
    btn = 5'd0;
    key_space = 1'b0;
    step();
    chk("win_state", 32'(state1), 3);
    chk("win_flag", 32'(win1), 1);
    chk("win_nolose", 32'(lose1), 0);
    rst();
    chk("win_rst_state", 32'(state1), 0);
    chk("win_rst_flag", 32'(win1), 0);
    chk("phase1_drained", 32'(q.size()), 0);
    sel = 1'b1;
    rst();
    chk("sat_rst_full", 32'(full2), 0);
    tap();
    for (int i = 0; i < 11; i++) begin
      mole(1'b0, 3'd0);
      mole(1'b1, 3'(i % 5));
      act(5'(1 << (i % 5)), 1'b1, wsc[i], 0, i + 1);
    end
    chk("sat_score", 32'(score2), 15);
    chk("sat_full", 32'(full2), 1);
    chk("sat_state", 32'(state2), 1);
    step();
    step();
    chk("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
